// File: rtl/pipeline_hazard_sequencer_if.sv
// Pipeline hazard sequencer bus: pipeline register fields and hazard requests
// into the sequencer, and pipeline enables, debug state and perf counters out.
//   master : pipeline side, drives the hazard sources and perfClr
//   slave  : sequencer side, drives the enables, mdBusy, counters and state
interface pipeline_hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ID_EX_memRead;
  logic [4:0]       ID_EX_rt;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             branchTaken;
  logic             mdStart;
  logic             perfClr;

  logic             pcWrite;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             mdBusy;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;
  logic [1:0]       state;

  modport master (
    output ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, branchTaken, mdStart, perfClr,
    input  pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mdBusy, stallCount, flushCount, state
  );

  modport slave (
    input  ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, branchTaken, mdStart, perfClr,
    output pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mdBusy, stallCount, flushCount, state
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Single owner of the 5-stage pipeline enables: sequences load-use bubbles,
// taken-branch flushes and multi-cycle mult/div holds, and keeps saturating
// stall/flush performance counters.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of pipeline_hazard_sequencer_if
//                in  : ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt,
//                      branchTaken, mdStart, perfClr
//                out : pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble
//                      (combinational, same cycle), mdBusy, stallCount,
//                      flushCount, state (registered)
// The interface CNT_W must match this module's CNT_W.
module pipeline_hazard_sequencer #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  pipeline_hazard_sequencer_if.slave bus
);

  localparam int unsigned MD_CNT_W = 4;
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MD_ISSUE = 2'd2
  } state_t;

  state_t              curState;
  state_t              nextState;
  logic [MD_CNT_W-1:0] cnt;
  logic [MD_CNT_W-1:0] cntNext;
  logic                mdBusyReg;
  logic [CNT_W-1:0]    stallCnt;
  logic [CNT_W-1:0]    flushCnt;

  logic                loadUse;
  logic                pcWr;
  logic                ifIdWr;
  logic                ifIdFlush;
  logic                idExBubble;

  // Load in EX writing a register the instruction in ID reads; $zero never hazards.
  assign loadUse = bus.ID_EX_memRead && (bus.ID_EX_rt != 5'd0) &&
                   ((bus.ID_EX_rt == bus.IF_ID_rs) || (bus.ID_EX_rt == bus.IF_ID_rt));

  // Next state and same-cycle pipeline enables; all enables held low in reset.
  always_comb begin
    nextState  = RUN;
    cntNext    = cnt;
    pcWr       = 1'b0;
    ifIdWr     = 1'b0;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    if (rst_n) begin
      case (curState)
        RUN: begin
          if (bus.branchTaken) begin
            // Flush wins over a coincident load-use: the stalled instruction is squashed anyway.
            pcWr       = 1'b1;
            ifIdWr     = 1'b1;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (loadUse) begin
            idExBubble = 1'b1;
          end else if (bus.mdStart) begin
            idExBubble = 1'b1;
            cntNext    = MD_LOAD;
            nextState  = (MD_LOAD != '0) ? MD_WAIT : MD_ISSUE;
          end else begin
            pcWr   = 1'b1;
            ifIdWr = 1'b1;
          end
        end
        MD_WAIT: begin
          // EX only holds bubbles here, so branch/load-use cannot occur.
          idExBubble = 1'b1;
          cntNext    = cnt - MD_CNT_W'(1);
          nextState  = (cnt <= MD_CNT_W'(1)) ? MD_ISSUE : MD_WAIT;
        end
        MD_ISSUE: begin
          // mdStart is still the same instruction leaving ID; do not re-trigger.
          pcWr      = 1'b1;
          ifIdWr    = 1'b1;
          nextState = RUN;
        end
        default: nextState = RUN;
      endcase
    end
  end

  // State, mult/div countdown and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState  <= RUN;
      cnt       <= '0;
      mdBusyReg <= 1'b0;
      stallCnt  <= '0;
      flushCnt  <= '0;
    end else begin
      curState  <= nextState;
      cnt       <= cntNext;
      mdBusyReg <= (nextState == MD_WAIT);
      if (bus.perfClr) begin
        stallCnt <= '0;
        flushCnt <= '0;
      end else begin
        if (!pcWr && (stallCnt != CNT_MAX)) stallCnt <= stallCnt + CNT_W'(1);
        if (ifIdFlush && (flushCnt != CNT_MAX)) flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

  assign bus.pcWrite      = pcWr;
  assign bus.IF_ID_write  = ifIdWr;
  assign bus.IF_ID_flush  = ifIdFlush;
  assign bus.ID_EX_bubble = idExBubble;
  assign bus.mdBusy       = mdBusyReg;
  assign bus.stallCount   = stallCnt;
  assign bus.flushCount   = flushCnt;
  assign bus.state        = curState;

endmodule
